// File: rtl/power_meter_pkg.sv
// power_meter_pkg: shared state encoding, default widths and the saturating average helper
package power_meter_pkg;
    localparam int ACC_W_DEF    = 48;
    localparam int RES_W_DEF    = 32;
    localparam int GAP_W_DEF    = 16;
    localparam int LOG2_MAX_DEF = 16;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, LATCH, GAP} state_t;

    // Divide by 2^l, clamping to the all-ones value of a res_w-bit result
    function automatic logic [127:0] sat_shift(input logic [127:0] v, input logic [4:0] l, input int res_w);
        logic [127:0] s;
        s = v >> l;
        return (s >> res_w) != '0 ? (128'd1 << res_w) - 128'd1 : s;
    endfunction
endpackage

// File: rtl/pm_result_reg.sv
// pm_result_reg: result holding register with valid/ready handshake and sticky overrun
module pm_result_reg #(
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RES_W-1:0] load_data,
    input  logic             res_ready,
    input  logic             overrun_clr,
    output logic [RES_W-1:0] res_data,
    output logic             res_valid,
    output logic             overrun
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) res_data <= load_data;
            res_valid <= load || (res_valid && !res_ready);
            // a new result landing on an unread one wins over a clear in the same cycle
            overrun   <= (load && res_valid && !res_ready) || (overrun && !overrun_clr);
        end
endmodule

// File: rtl/power_meter_scheduler.sv
// power_meter_scheduler: clear/accumulate/latch window sequencer for the power accumulator
module power_meter_scheduler import power_meter_pkg::*; #(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int RES_W    = RES_W_DEF,
    parameter int LOG2_MAX = LOG2_MAX_DEF,
    parameter int GAP_W    = GAP_W_DEF
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             enable,
    input  logic             start,
    input  logic [4:0]       cfg_log2_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             sample_stb,
    output logic             acc_clear,
    output logic             acc_en,
    input  logic [ACC_W-1:0] acc_sum,
    output logic [RES_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    input  logic             overrun_clr,
    output logic             overrun,
    output logic             busy
);
    state_t state, state_n;
    logic [4:0] len_l, len_c;
    logic [GAP_W-1:0] gap_l, gap_cnt;
    logic [LOG2_MAX-1:0] cnt, last_cnt;
    logic one_shot, abort, last, gap_done, relatch;
    logic [RES_W-1:0] avg;

    assign len_c    = cfg_log2_len > 5'(LOG2_MAX) ? 5'(LOG2_MAX) : cfg_log2_len;
    assign last_cnt = ~({LOG2_MAX{1'b1}} << len_l);
    assign last     = sample_stb && cnt == last_cnt;
    // a one-shot run ignores enable until its window completes
    assign abort    = !enable && !one_shot;
    assign gap_done = gap_cnt == gap_l;
    assign relatch  = (state == IDLE && (enable || start)) || (state == GAP && gap_done && enable);
    assign avg      = RES_W'(sat_shift(128'(acc_sum), len_l, RES_W));

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            len_l    <= '0;
            gap_l    <= '0;
            one_shot <= 1'b0;
            cnt      <= '0;
            gap_cnt  <= '0;
        end else begin
            if (relatch) begin
                len_l    <= len_c;
                gap_l    <= cfg_gap;
                one_shot <= state == IDLE && !enable;
            end
            cnt     <= state == CLEAR ? '0 : (state == ACCUM && sample_stb) ? cnt + LOG2_MAX'(1) : cnt;
            gap_cnt <= state == GAP ? gap_cnt + GAP_W'(1) : '0;
        end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (enable || start) ? CLEAR : IDLE;
            CLEAR:   state_n = abort ? IDLE : ACCUM;
            ACCUM:   state_n = abort ? IDLE : last ? LATCH : ACCUM;
            LATCH:   state_n = GAP;
            GAP:     state_n = !gap_done ? GAP : enable ? CLEAR : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        acc_clear = state == CLEAR;
        acc_en    = state == ACCUM && !abort;
        busy      = state != IDLE;
    end

    pm_result_reg #(.RES_W(RES_W)) u_result (
        .clk        (ACLK),
        .rst        (ARESET),
        .load       (state == LATCH),
        .load_data  (avg),
        .res_ready  (res_ready),
        .overrun_clr(overrun_clr),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .overrun    (overrun)
    );
endmodule
